issue_scoreboard: RTL and testbench

//  Sequences issue of decoded instructions into the execute pipeline. Consumes
//  the decoder's rd/rs1/rs2 indices and holds per-register pending-write state.

---
 rtl/issue_scoreboard_if.sv | 39 +++
 rtl/issue_scoreboard.sv | 111 +++++++++++
 tb/tb_issue_scoreboard.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/issue_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : issue_scoreboard_if
// Description : Issue / writeback / drain bundle between decode and scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
interface issue_scoreboard_if #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_WIDTH       = 32
) ();
    localparam int BUSY_W = $clog2(MAX_OUTSTANDING + 1);

    logic                 issue_valid;
    logic [4:0]           issue_rd;
    logic [4:0]           issue_rs1;
    logic [4:0]           issue_rs2;
    logic                 issue_ready;
    logic                 flush;
    logic                 wb_valid;
    logic [4:0]           wb_rd;
    logic                 drain_req;
    logic                 drain_done;
    logic [BUSY_W-1:0]    busy_cnt;
    logic [CNT_WIDTH-1:0] stall_cnt;
    logic                 wb_err;

    modport master (
        output issue_valid, issue_rd, issue_rs1, issue_rs2, flush,
        output wb_valid, wb_rd, drain_req,
        input  issue_ready, drain_done, busy_cnt, stall_cnt, wb_err
    );

    modport slave (
        input  issue_valid, issue_rd, issue_rs1, issue_rs2, flush,
        input  wb_valid, wb_rd, drain_req,
        output issue_ready, drain_done, busy_cnt, stall_cnt, wb_err
    );
endinterface
`default_nettype wire

// File: rtl/issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : issue_scoreboard
// Description : Per-register pending-write scoreboard with hazard stall,
//               outstanding-write limit and drain sequencing.
// Revision    : 1.0 - initial release
// ============================================================================
module issue_scoreboard #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_WIDTH       = 32
) (
    input  wire logic          clk,
    input  wire logic          reset,
    issue_scoreboard_if.slave  sb
);
    localparam int                BUSY_W     = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [BUSY_W-1:0] c_BUSY_MAX = BUSY_W'(MAX_OUTSTANDING);
    localparam logic [BUSY_W-1:0] c_BUSY_ONE = BUSY_W'(1);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [31:1]          r_pending;
    logic [31:1]          w_pend_nxt;
    logic [31:0]          w_pend;
    logic [BUSY_W-1:0]    r_busy_cnt;
    logic [BUSY_W-1:0]    w_busy_nxt;
    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic                 r_wb_err;

    logic w_hazard;
    logic w_ready;
    logic w_track;
    logic w_wb_hit;
    logic w_wb_bad;
    logic w_stall;

    // x0 never holds a pending write, so bit 0 reads as a constant zero.
    assign w_pend = {r_pending, 1'b0};

    assign w_hazard = w_pend[sb.issue_rs1] | w_pend[sb.issue_rs2] | w_pend[sb.issue_rd] |
                      ((r_busy_cnt == c_BUSY_MAX) && (sb.issue_rd != 5'd0));
    assign w_ready  = (r_state == S_RUN) && !sb.drain_req && !sb.flush && !w_hazard;
    assign w_track  = sb.issue_valid && w_ready && (sb.issue_rd != 5'd0);
    assign w_wb_hit = sb.wb_valid && (sb.wb_rd != 5'd0) &&  w_pend[sb.wb_rd];
    assign w_wb_bad = sb.wb_valid && (sb.wb_rd != 5'd0) && !w_pend[sb.wb_rd];
    assign w_stall  = sb.issue_valid && !w_ready;

    always_comb begin
        w_pend_nxt = r_pending;
        if (w_wb_hit) begin
            w_pend_nxt[sb.wb_rd] = 1'b0;
        end
        if (w_track) begin
            w_pend_nxt[sb.issue_rd] = 1'b1;
        end
    end

    always_comb begin
        w_busy_nxt = r_busy_cnt;
        if (w_track && !w_wb_hit) begin
            w_busy_nxt = r_busy_cnt + c_BUSY_ONE;
        end else if (!w_track && w_wb_hit) begin
            w_busy_nxt = r_busy_cnt - c_BUSY_ONE;
        end
    end

    // DRAIN exits on the post-writeback count so the final retire and DONE
    // land on consecutive cycles.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN:   if (sb.drain_req) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_busy_nxt == '0) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_RUN;
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_RUN;
            r_pending   <= '0;
            r_busy_cnt  <= '0;
            r_stall_cnt <= '0;
            r_wb_err    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pending  <= w_pend_nxt;
            r_busy_cnt <= w_busy_nxt;
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
            end
            if (w_wb_bad) begin
                r_wb_err <= 1'b1;
            end
        end
    end

    assign sb.issue_ready = w_ready;
    assign sb.drain_done  = (r_state == S_DONE);
    assign sb.busy_cnt    = r_busy_cnt;
    assign sb.stall_cnt   = r_stall_cnt;
    assign sb.wb_err      = r_wb_err;
endmodule
`default_nettype wire

// File: tb/tb_issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_issue_scoreboard
// Description : Directed self-checking bench for issue_scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_issue_scoreboard;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    issue_scoreboard_if #(.MAX_OUTSTANDING(4), .CNT_WIDTH(32)) bus ();
    issue_scoreboard_if #(.MAX_OUTSTANDING(1), .CNT_WIDTH(3))  sat ();

    issue_scoreboard #(.MAX_OUTSTANDING(4), .CNT_WIDTH(32)) u_dut (
        .clk   (clk),
        .reset (rst),
        .sb    (bus.slave)
    );

    // Narrow counter instance so saturation is reachable in a short run.
    issue_scoreboard #(.MAX_OUTSTANDING(1), .CNT_WIDTH(3)) u_sat (
        .clk   (clk),
        .reset (rst),
        .sb    (sat.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2);
        bus.issue_valid = v;
        bus.issue_rd    = rd;
        bus.issue_rs1   = rs1;
        bus.issue_rs2   = rs2;
    endtask

    task automatic wb(input logic v, input logic [4:0] rd);
        bus.wb_valid = v;
        bus.wb_rd    = rd;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 5'd0);
        wb(1'b0, 5'd0);
        bus.flush     = 1'b0;
        bus.drain_req = 1'b0;
        sat.issue_valid = 1'b0;
        sat.issue_rd    = 5'd0;
        sat.issue_rs1   = 5'd0;
        sat.issue_rs2   = 5'd0;
        sat.flush       = 1'b0;
        sat.wb_valid    = 1'b0;
        sat.wb_rd       = 5'd0;
        sat.drain_req   = 1'b0;

        cyc();
        cyc();
        rst = 1'b0;
        #1;
        chk("rst_busy",  64'(bus.busy_cnt), 64'd0);
        chk("rst_stall", 64'(bus.stall_cnt), 64'd0);
        chk("rst_err",   64'(bus.wb_err), 64'd0);
        chk("rst_done",  64'(bus.drain_done), 64'd0);
        chk("rst_ready", 64'(bus.issue_ready), 64'd1);

        // RAW: lw x5 then dependent add
        cyc(); drive(1'b1, 5'd5, 5'd0, 5'd0); #1;
        chk("raw_lw_ready", 64'(bus.issue_ready), 64'd1);
        cyc(); drive(1'b1, 5'd6, 5'd5, 5'd0); #1;
        chk("raw_stall1", 64'(bus.issue_ready), 64'd0);
        cyc(); #1;
        chk("raw_stall2", 64'(bus.issue_ready), 64'd0);
        cyc(); wb(1'b1, 5'd5); #1;
        chk("raw_no_bypass", 64'(bus.issue_ready), 64'd0);
        cyc(); wb(1'b0, 5'd0); #1;
        chk("raw_unblock", 64'(bus.issue_ready), 64'd1);
        chk("raw_stall_cnt", 64'(bus.stall_cnt), 64'd3);
        cyc(); drive(1'b0, 5'd0, 5'd0, 5'd0); wb(1'b1, 5'd6); #1;
        chk("raw_add_inflight", 64'(bus.busy_cnt), 64'd1);
        cyc(); wb(1'b0, 5'd0); #1;
        chk("raw_clean", 64'(bus.busy_cnt), 64'd0);

        // Outstanding-write limit
        for (int r = 1; r <= 4; r++) begin
            cyc(); drive(1'b1, 5'(r), 5'd0, 5'd0); #1;
            chk("lim_fill_ready", 64'(bus.issue_ready), 64'd1);
        end
        cyc(); drive(1'b1, 5'd6, 5'd0, 5'd0); #1;
        chk("lim_busy4", 64'(bus.busy_cnt), 64'd4);
        chk("lim_rd6_stall", 64'(bus.issue_ready), 64'd0);
        cyc(); drive(1'b1, 5'd0, 5'd0, 5'd0); #1;
        chk("lim_store_fires", 64'(bus.issue_ready), 64'd1);
        cyc(); drive(1'b1, 5'd6, 5'd0, 5'd0); wb(1'b1, 5'd2); #1;
        chk("lim_store_untracked", 64'(bus.busy_cnt), 64'd4);
        chk("lim_wb_cycle_stall", 64'(bus.issue_ready), 64'd0);
        cyc(); wb(1'b0, 5'd0); #1;
        chk("lim_busy3", 64'(bus.busy_cnt), 64'd3);
        chk("lim_rd6_fires", 64'(bus.issue_ready), 64'd1);
        cyc(); drive(1'b0, 5'd0, 5'd0, 5'd0); wb(1'b1, 5'd1); #1;
        chk("lim_busy_back4", 64'(bus.busy_cnt), 64'd4);
        cyc(); wb(1'b1, 5'd3);
        cyc(); wb(1'b1, 5'd4);
        cyc(); wb(1'b1, 5'd6);
        cyc(); wb(1'b0, 5'd0); #1;
        chk("lim_clean", 64'(bus.busy_cnt), 64'd0);

        // Same-cycle fire and writeback
        cyc(); drive(1'b1, 5'd7, 5'd0, 5'd0); #1;
        chk("same_fire7", 64'(bus.issue_ready), 64'd1);
        cyc(); drive(1'b1, 5'd8, 5'd0, 5'd0); wb(1'b1, 5'd7); #1;
        chk("same_fire8", 64'(bus.issue_ready), 64'd1);
        cyc(); drive(1'b0, 5'd0, 5'd8, 5'd0); wb(1'b0, 5'd0); #1;
        chk("same_busy1", 64'(bus.busy_cnt), 64'd1);
        chk("same_pend8", 64'(bus.issue_ready), 64'd0);
        chk("same_no_err", 64'(bus.wb_err), 64'd0);
        drive(1'b0, 5'd0, 5'd7, 5'd0); #1;
        chk("same_pend7_clear", 64'(bus.issue_ready), 64'd1);
        cyc(); wb(1'b1, 5'd8);
        cyc(); wb(1'b0, 5'd0); #1;
        chk("same_clean", 64'(bus.busy_cnt), 64'd0);

        // Writeback to non-pending register, then wb_rd=0 ignored
        cyc(); wb(1'b1, 5'd9);
        cyc(); drive(1'b1, 5'd9, 5'd0, 5'd0); wb(1'b1, 5'd0); #1;
        chk("err_set", 64'(bus.wb_err), 64'd1);
        chk("err_busy", 64'(bus.busy_cnt), 64'd0);
        chk("err_fire9", 64'(bus.issue_ready), 64'd1);
        cyc(); drive(1'b0, 5'd0, 5'd0, 5'd0); wb(1'b1, 5'd9); #1;
        chk("err_wb0_ignored", 64'(bus.busy_cnt), 64'd1);
        cyc(); wb(1'b0, 5'd0); #1;
        chk("err_clean", 64'(bus.busy_cnt), 64'd0);
        chk("err_sticky", 64'(bus.wb_err), 64'd1);

        // Drain with two writes outstanding
        cyc(); drive(1'b1, 5'd10, 5'd0, 5'd0);
        cyc(); drive(1'b1, 5'd11, 5'd0, 5'd0);
        cyc(); drive(1'b1, 5'd12, 5'd0, 5'd0); bus.drain_req = 1'b1; #1;
        chk("drn_busy2", 64'(bus.busy_cnt), 64'd2);
        chk("drn_req_blocks", 64'(bus.issue_ready), 64'd0);
        cyc(); bus.drain_req = 1'b0; #1;
        chk("drn_state_blocks", 64'(bus.issue_ready), 64'd0);
        cyc();
        cyc(); wb(1'b1, 5'd10);
        cyc(); wb(1'b0, 5'd0); #1;
        chk("drn_busy1", 64'(bus.busy_cnt), 64'd1);
        chk("drn_done_low4", 64'(bus.drain_done), 64'd0);
        cyc(); wb(1'b1, 5'd11); #1;
        chk("drn_done_low5", 64'(bus.drain_done), 64'd0);
        cyc(); wb(1'b0, 5'd0); #1;
        chk("drn_done_pulse", 64'(bus.drain_done), 64'd1);
        chk("drn_busy0", 64'(bus.busy_cnt), 64'd0);
        chk("drn_done_blocks", 64'(bus.issue_ready), 64'd0);
        cyc(); #1;
        chk("drn_done_end", 64'(bus.drain_done), 64'd0);
        chk("drn_run_ready", 64'(bus.issue_ready), 64'd1);
        cyc(); drive(1'b0, 5'd0, 5'd0, 5'd0); wb(1'b1, 5'd12); #1;
        chk("drn_rd12_fired", 64'(bus.busy_cnt), 64'd1);
        chk("drn_stall_cnt", 64'(bus.stall_cnt), 64'd12);
        cyc(); wb(1'b0, 5'd0); #1;
        chk("drn_clean", 64'(bus.busy_cnt), 64'd0);

        // Empty drain
        cyc(); bus.drain_req = 1'b1;
        cyc(); bus.drain_req = 1'b0; #1;
        chk("edrn_low1", 64'(bus.drain_done), 64'd0);
        cyc(); #1;
        chk("edrn_pulse2", 64'(bus.drain_done), 64'd1);
        cyc(); #1;
        chk("edrn_end", 64'(bus.drain_done), 64'd0);
        chk("edrn_ready", 64'(bus.issue_ready), 64'd1);

        // Reset while draining
        cyc(); drive(1'b1, 5'd13, 5'd0, 5'd0);
        cyc(); drive(1'b0, 5'd0, 5'd0, 5'd0); bus.drain_req = 1'b1;
        cyc(); bus.drain_req = 1'b0; #1;
        chk("rdrn_in_drain", 64'(bus.issue_ready), 64'd0);
        chk("rdrn_busy1", 64'(bus.busy_cnt), 64'd1);
        rst = 1'b1;
        cyc(); rst = 1'b0; drive(1'b0, 5'd13, 5'd13, 5'd0); #1;
        chk("rdrn_busy", 64'(bus.busy_cnt), 64'd0);
        chk("rdrn_stall", 64'(bus.stall_cnt), 64'd0);
        chk("rdrn_err", 64'(bus.wb_err), 64'd0);
        chk("rdrn_done", 64'(bus.drain_done), 64'd0);
        chk("rdrn_ready", 64'(bus.issue_ready), 64'd1);

        // Stall counter saturation on the 3-bit instance
        cyc(); sat.issue_valid = 1'b1; sat.flush = 1'b1; #1;
        chk("sat_flush_ready", 64'(sat.issue_ready), 64'd0);
        repeat (6) cyc();
        #1;
        chk("sat_count6", 64'(sat.stall_cnt), 64'd6);
        repeat (3) cyc();
        #1;
        chk("sat_hold_ones", 64'(sat.stall_cnt), 64'd7);
        chk("sat_busy", 64'(sat.busy_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
